// File: rtl/pipo_stereo_serializer_if.sv
// Parallel-in / serial-out bundle between the stereo capture stage and the serializer.
// Master drives the word pair and strobe; slave returns the serial lines and status.
interface pipo_stereo_serializer_if #(
   parameter int WIDTH = 16
);
   logic             Load;
   logic [WIDTH-1:0] DataL;
   logic [WIDTH-1:0] DataR;
   logic             FrameOut;
   logic             OutL;
   logic             OutR;
   logic             Busy;
   logic             Overrun;

   modport master (
      output Load, DataL, DataR,
      input  FrameOut, OutL, OutR, Busy, Overrun
   );

   modport slave (
      input  Load, DataL, DataR,
      output FrameOut, OutL, OutR, Busy, Overrun
   );
endinterface

// File: rtl/pipo_stereo_serializer.sv
// Serializes 16-bit left/right word pairs MSB-first with a frame-sync pulse on each MSB.
// One pending pair is buffered so back-to-back frames run without a gap.
module pipo_stereo_serializer #(
   parameter int WIDTH = 16
) (
   input logic                     Dclk,
   input logic                     Clear,
   pipo_stereo_serializer_if.slave bus
);
   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] MSB_POS = BW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e           state_q, state_d;
   logic [BW-1:0]    bitpos_q, bitpos_d;
   logic [WIDTH-1:0] shl_q, shl_d, shr_q, shr_d;
   logic [WIDTH-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic             pend_vld_q, pend_vld_d;
   logic             frame_q, frame_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave a value unassigned and infer a latch.
      state_d    = state_q;
      bitpos_d   = bitpos_q;
      shl_d      = shl_q;
      shr_d      = shr_q;
      pend_l_d   = pend_l_q;
      pend_r_d   = pend_r_q;
      pend_vld_d = pend_vld_q;
      overrun_d  = overrun_q;
      frame_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.Load) begin
               shl_d    = bus.DataL;
               shr_d    = bus.DataR;
               bitpos_d = MSB_POS;
               frame_d  = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bitpos_q == '0) begin
               // Frame-end edge: the pending pair has priority over a fresh Load.
               if (pend_vld_q) begin
                  shl_d    = pend_l_q;
                  shr_d    = pend_r_q;
                  bitpos_d = MSB_POS;
                  frame_d  = 1'b1;
                  if (bus.Load) begin
                     pend_l_d = bus.DataL;
                     pend_r_d = bus.DataR;
                  end else begin
                     pend_vld_d = 1'b0;
                  end
               end else if (bus.Load) begin
                  shl_d    = bus.DataL;
                  shr_d    = bus.DataR;
                  bitpos_d = MSB_POS;
                  frame_d  = 1'b1;
               end else begin
                  shl_d    = '0;
                  shr_d    = '0;
                  bitpos_d = MSB_POS;
                  state_d  = IDLE;
               end
            end else begin
               shl_d    = shl_q << 1;
               shr_d    = shr_q << 1;
               bitpos_d = bitpos_q - BW'(1);
               if (bus.Load) begin
                  if (!pend_vld_q) begin
                     pend_l_d   = bus.DataL;
                     pend_r_d   = bus.DataR;
                     pend_vld_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT) | pend_vld_d;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Dclk) begin
      if (Clear) begin
         state_q    <= IDLE;
         bitpos_q   <= MSB_POS;
         shl_q      <= '0;
         shr_q      <= '0;
         pend_l_q   <= '0;
         pend_r_q   <= '0;
         pend_vld_q <= 1'b0;
         frame_q    <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitpos_q   <= bitpos_d;
         shl_q      <= shl_d;
         shr_q      <= shr_d;
         pend_l_q   <= pend_l_d;
         pend_r_q   <= pend_r_d;
         pend_vld_q <= pend_vld_d;
         frame_q    <= frame_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.FrameOut = frame_q;
   assign bus.OutL     = shl_q[WIDTH-1];
   assign bus.OutR     = shr_q[WIDTH-1];
   assign bus.Busy     = busy_q;
   assign bus.Overrun  = overrun_q;
endmodule
